// File: rtl/alu_xbar_pe.sv
// Single-ALU CGRA processing element: a 4x4 operand crossbar, a registered ALU,
// a 2x1 output switch, and an 11-bit serial configuration chain.
module alu_xbar_pe #(
    parameter int unsigned size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            config_en,
    input  logic            config_in,
    output logic            config_out,
    input  logic [size-1:0] in0,
    input  logic [size-1:0] in1,
    input  logic [size-1:0] in2,
    output logic [size-1:0] out0,
    output logic [size-1:0] out1
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_AND = 2'b11
    } alu_op_e;

    logic [10:0]     cfg_q, cfg_d;
    logic [size-1:0] alu_q, alu_d;

    alu_op_e         alu_op;
    logic            out_sel;
    logic [1:0]      sel   [4];
    logic [size-1:0] src   [4];
    logic [size-1:0] x     [4];

    assign alu_op  = alu_op_e'(cfg_q[10:9]);
    assign out_sel = cfg_q[8];
    assign sel[0]  = cfg_q[7:6];
    assign sel[1]  = cfg_q[5:4];
    assign sel[2]  = cfg_q[3:2];
    assign sel[3]  = cfg_q[1:0];

    // Source order matches the select encoding: in0, in1, registered result, in2.
    assign src[0] = in0;
    assign src[1] = in1;
    assign src[2] = alu_q;
    assign src[3] = in2;

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            x[k] = src[sel[k]];
        end
    end

    always_comb begin
        cfg_d = cfg_q;
        if (config_en) begin
            cfg_d = {cfg_q[9:0], config_in};
        end
    end

    always_comb begin
        alu_d = '0;
        unique case (alu_op)
            OP_ADD: alu_d = x[0] + x[1];
            OP_SUB: alu_d = x[0] - x[1];
            OP_MUL: alu_d = x[0] * x[1];
            OP_AND: alu_d = x[0] & x[1];
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg_q <= '0;
            alu_q <= '0;
        end else begin
            cfg_q <= cfg_d;
            alu_q <= alu_d;
        end
    end

    assign config_out = cfg_q[10];
    assign out0       = out_sel ? x[2] : alu_q;
    assign out1       = x[3];

endmodule

// File: tb/tb_alu_xbar_pe.sv
// Directed bench for alu_xbar_pe: a behavioural model checked on every falling
// edge, plus hand-computed literal expectations along the test plan.
module tb_alu_xbar_pe;

    logic        clk = 1'b0;
    logic        reset;
    logic        config_en;
    logic        config_in;
    logic        config_out;
    logic [31:0] in0, in1, in2;
    logic [31:0] out0, out1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    alu_xbar_pe #(.size(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .config_en  (config_en),
        .config_in  (config_in),
        .config_out (config_out),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .out0       (out0),
        .out1       (out1)
    );

    always #5 clk = ~clk;

    // Model state: the configuration word and the accumulated ALU result.
    logic [10:0] m_cfg = '0;
    logic [31:0] m_acc = '0;

    function automatic logic [31:0] route(input logic [1:0] s);
        logic [31:0] table_v [4];
        table_v[0] = in0;
        table_v[1] = in1;
        table_v[2] = m_acc;
        table_v[3] = in2;
        return table_v[s];
    endfunction

    function automatic logic [31:0] xb(input int k);
        logic [1:0] s;
        s = m_cfg[7 - 2*k -: 2];
        return route(s);
    endfunction

    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return a * b;
            default: return a & b;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [31:0] nxt;
        if (!reset) begin
            m_cfg = '0;
            m_acc = '0;
        end else begin
            nxt = alu_ref(m_cfg[10:9], xb(0), xb(1));
            if (config_en) m_cfg = {m_cfg[9:0], config_in};
            m_acc = nxt;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out0", out0, m_cfg[8] ? xb(2) : m_acc);
            check("model_out1", out1, xb(3));
            check("model_cfg_out", {31'd0, config_out}, {31'd0, m_cfg[10]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic shift_word(input logic [10:0] w);
        for (int i = 10; i >= 0; i--) begin
            config_en = 1'b1;
            config_in = w[i];
            tick();
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    initial begin
        logic [31:0] base;
        logic [10:0] w1, w2;

        reset = 1'b0; config_en = 1'b0; config_in = 1'b0;
        in0 = 32'd5; in1 = 32'd0; in2 = 32'd0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_out0", out0, 32'd0);
        check("rst_out1", out1, 32'd5);
        check("rst_cfg_out", {31'd0, config_out}, 32'd0);

        reset = 1'b1;
        tick();
        check("post_rst_add", out0, 32'd10);

        shift_word(11'b00_0_00_01_00_00);
        in0 = 32'd7; in1 = 32'd9;
        tick();
        check("add_7_9", out0, 32'd16);
        in0 = 32'hFFFF_FFFF; in1 = 32'd1;
        tick();
        check("add_wrap", out0, 32'd0);

        shift_word(11'b01_0_00_01_00_00);
        in0 = 32'd3; in1 = 32'd5;
        tick();
        check("sub_3_5", out0, 32'hFFFF_FFFE);

        shift_word(11'b10_0_00_01_00_00);
        in0 = 32'h1_0000; in1 = 32'h1_0000;
        tick();
        check("mul_wrap", out0, 32'd0);
        in0 = 32'd6; in1 = 32'd7;
        tick();
        check("mul_6_7", out0, 32'd42);

        shift_word(11'b11_0_00_01_00_00);
        in0 = 32'hF0F0; in1 = 32'hFF00;
        tick();
        check("and", out0, 32'hF000);

        // Accumulator: each cycle adds in1=1 to the fed-back result.
        in1 = 32'd1;
        shift_word(11'b00_0_10_01_00_00);
        base = m_acc;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("acc_step", out0, base + 32'(k));
        end

        shift_word(11'b00_1_00_01_11_01);
        in2 = 32'hAA; in1 = 32'h55;
        #1;
        check("sw_out0", out0, 32'hAA);
        check("sw_out1", out1, 32'h55);
        in2 = 32'h1234; in1 = 32'h9876;
        #1;
        check("sw_out0_b", out0, 32'h1234);
        check("sw_out1_b", out1, 32'h9876);

        w1 = 11'b101_1001_1100;
        w2 = 11'b010_0110_0011;
        shift_word(w1);
        for (int i = 0; i < 11; i++) begin
            check("chain_replay", {31'd0, config_out}, {31'd0, w1[10 - i]});
            config_en = 1'b1;
            config_in = w2[10 - i];
            tick();
        end
        config_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("chain_hold", {31'd0, config_out}, {31'd0, w2[10]});
        end

        // Reset during a shift (with config_en still high) clears the chain.
        config_en = 1'b1;
        config_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        tick();
        check("rst_mid_cfg_out", {31'd0, config_out}, 32'd0);
        check("rst_mid_out0", out0, 32'd0);
        reset = 1'b1;
        config_en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("rst_mid_cfg_zero", {31'd0, config_out}, 32'd0);

        chk_en = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
